// File: rtl/rr_priority_encoder.sv
// Registered priority encoder: fixed (highest index) or round-robin selection, one-entry valid/ready output.
// Optional statistics (grant_cnt, ptr_dbg) enabled by defining RR_PRIORITY_ENCODER_STATS_EN.
module rr_priority_encoder #(
  parameter int WIDTH = 8,
  localparam int IW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] req,
  input  logic             mode,
  output logic [IW-1:0]    out_idx,
  output logic [WIDTH-1:0] out_gnt,
  output logic             out_valid,
  input  logic             out_ready
`ifdef RR_PRIORITY_ENCODER_STATS_EN
  ,
  output logic [15:0]      grant_cnt,
  output logic [IW-1:0]    ptr_dbg
`endif
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t           state_p0, state_d;
  logic [IW-1:0]    ptr_p0;
  logic [IW-1:0]    idx_p0;
  logic [WIDTH-1:0] gnt_p0;
  logic [IW-1:0]    base;
  logic [IW-1:0]    sel;
  logic             any_req;
  logic             load;

  assign any_req = |req;

  // Last match wins: lowest priority at base, rising through WIDTH-1, then 0 up to base-1 highest.
  always_comb begin
    sel  = '0;
    base = mode ? ptr_p0 : '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (req[i] && (i >= int'(base))) sel = IW'(i);
    end
    for (int i = 0; i < WIDTH; i++) begin
      if (req[i] && (i < int'(base))) sel = IW'(i);
    end
  end

  always_comb begin
    state_d = state_p0;
    load    = (state_p0 == EMPTY) || out_ready;
    if (load) state_d = any_req ? FULL : EMPTY;
  end

  // Stage p0: output register and rotating pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_p0 <= EMPTY;
      ptr_p0   <= '0;
      idx_p0   <= '0;
      gnt_p0   <= '0;
    end else begin
      state_p0 <= state_d;
      if (load && any_req) begin
        idx_p0 <= sel;
        gnt_p0 <= WIDTH'(1) << sel;
        ptr_p0 <= sel;
      end
    end
  end

  assign out_valid = (state_p0 == FULL);
  assign out_idx   = idx_p0;
  assign out_gnt   = gnt_p0;

`ifdef RR_PRIORITY_ENCODER_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_cnt <= '0;
    end else if (out_valid && out_ready && (grant_cnt != 16'hFFFF)) begin
      grant_cnt <= grant_cnt + 16'd1;
    end
  end

  assign ptr_dbg = ptr_p0;
`endif

endmodule

// File: doc/rr_priority_encoder.md
Name: rr_priority_encoder

Overview:
- Registered, parametrised successor to the combinational priority encoder.
- Encodes a WIDTH-bit request vector into an index plus a one-hot grant.
- Two run-time modes: fixed priority (highest set index wins) or round-robin with a rotating pointer.
- Result is held in a one-entry output register under a valid/ready handshake, so it can feed back-pressured consumers such as interrupt or arbitration logic.

Parameters:
- WIDTH, 8, number of request lines; legal range 2..256, need not be a power of two.
- IW, $clog2(WIDTH), index width; derived, never overridden.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  WIDTH  request vector; level-sensitive, sampled every cycle.
- mode  in  1  0 = fixed priority (highest index), 1 = round-robin.
- out_idx  out  IW  encoded index of the granted request.
- out_gnt  out  WIDTH  one-hot copy of the grant, `1 << out_idx`.
- out_valid  out  1  output register holds a grant.
- out_ready  in  1  consumer accepts the current grant.

Behaviour:
- Reset (async assert, sync release) clears the following:
  - out_valid=0, out_idx=0, out_gnt=0, pointer ptr=0.
- Output register FSM, two states, tracked by out_valid:
  - EMPTY (out_valid=0) and FULL (out_valid=1).
- Load condition: load = !out_valid | out_ready.
  - load & |req: capture the selected index into out_idx and out_gnt, set out_valid=1, update ptr := selected index.
  - load & ~|req: out_valid := 0; out_idx and out_gnt hold their old values.
  - !load (FULL & !out_ready): all outputs and ptr hold; req changes are ignored.
- Latency and throughput:
  - Latency is 1 cycle from req sample to out_valid.
  - With out_ready tied high, one new grant is issued per cycle.
- Fixed mode:
  - Select the highest set index of req.
  - This is the same result as the legacy encoder, registered.
- Round-robin mode search order:
  - Scan ptr-1 down to 0, then WIDTH-1 down to ptr; the first set bit wins.
  - With ptr=0 the order is WIDTH-1..0, identical to fixed mode.
  - The most recently granted index has lowest priority next time.
- ptr behaviour:
  - ptr updates on every capture in both modes.
  - A mode switch therefore needs no extra cycle; the new mode applies at the next capture.
- Boundary conditions:
  - Non-power-of-two WIDTH: wrap goes to WIDTH-1; indices >= WIDTH are never produced.
  - Single request: that request is always granted, regardless of mode or ptr.
  - req deasserting while FULL: the held grant stays valid until consumed. Requesters must tolerate a stale grant.
  - out_ready with out_valid=0: no effect beyond load.
- Invariants:
  - out_gnt is one-hot when out_valid=1.
  - out_gnt == (1 << out_idx) at all times after the first capture.
- Reset mid-operation discards any held grant immediately; the consumer sees out_valid drop asynchronously.

Optional Feature:
- Macro: RR_PRIORITY_ENCODER_STATS_EN.
- When defined:
  - Adds output grant_cnt [15:0].
  - It counts accepted handshakes (out_valid & out_ready) and saturates at 16'hFFFF.
  - Reset value is 0.
  - Adds output ptr_dbg [IW-1:0] mirroring ptr.
- When undefined:
  - Neither port nor any counter logic exists.
  - Functional behaviour is otherwise identical.

Test Plan:
- Reset: assert rst with req=8'hFF mid-stream -> out_valid=0, out_idx=0, out_gnt=0 in the same cycle; after release, the first grant is 7.
- Fixed mode, WIDTH=8, out_ready=1, req=8'b0010_0110 held -> out_idx=5, out_gnt=8'h20, every cycle after the first.
- Round-robin, WIDTH=8, out_ready=1, req=8'b1010_0100 held -> grant sequence 7,5,2,7,5,2.
- Back-pressure:
  - Setup: round-robin, req=8'h81, out_ready=0 for 3 cycles.
  - Required: out_idx stays 7 and ptr holds.
  - Then raise out_ready -> next grant is 0, then 7.
- Idle: req=0 with out_ready=1 -> out_valid=0 next cycle and out_idx holds. Then req=8'h08 -> out_valid=1 and out_idx=3 one cycle later.
- Non-power-of-two WIDTH=5, round-robin, req=5'b10011 -> grants 4,1,0,4; out_idx is never 5..7. With RR_PRIORITY_ENCODER_STATS_EN, grant_cnt=4 after 4 handshakes.
